// File: rtl/activation_skew_feeder_if.sv
// activation_skew_feeder_if: tile load port and skewed lane outputs between unified buffer, feeder and array.
interface activation_skew_feeder_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic              i_load;
    logic [DATA_W-1:0] i_in_00;
    logic [DATA_W-1:0] i_in_01;
    logic [DATA_W-1:0] i_in_10;
    logic [DATA_W-1:0] i_in_11;
    logic              o_load_ready;
    logic [DATA_W-1:0] o_lane0_data;
    logic              o_lane0_valid;
    logic [DATA_W-1:0] o_lane1_data;
    logic              o_lane1_valid;
    logic              o_busy;
    logic              o_done;
    logic [CNT_W-1:0]  o_tile_count;

    modport master (
        output i_load, i_in_00, i_in_01, i_in_10, i_in_11,
        input  o_load_ready, o_lane0_data, o_lane0_valid, o_lane1_data, o_lane1_valid,
               o_busy, o_done, o_tile_count
    );

    modport slave (
        input  i_load, i_in_00, i_in_01, i_in_10, i_in_11,
        output o_load_ready, o_lane0_data, o_lane0_valid, o_lane1_data, o_lane1_valid,
               o_busy, o_done, o_tile_count
    );
endinterface

// File: rtl/activation_skew_feeder.sv
// activation_skew_feeder: streams a 2x2 activation tile as two diagonally skewed lanes, one tile per 3-beat window.
// Define ACT_SKEW_DOUBLE_BUFFER_EN to add a shadow tile so back-to-back tiles feed without a bubble.
module activation_skew_feeder #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input logic clk,
    input logic reset,
    activation_skew_feeder_if.slave bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FEED = 1'b1;
    localparam int TW = 4 * DATA_W;

    logic [0:0]    r_state, w_state;
    logic [1:0]    r_beat, w_beat;
    logic [TW-1:0] r_tile, w_tile;
    logic [TW-1:0] w_in;
    logic          w_accept, w_last, w_b0, w_b1, w_b2;
`ifdef ACT_SKEW_DOUBLE_BUFFER_EN
    logic [TW-1:0] r_shadow, w_shadow;
    logic          r_shadow_full, w_shadow_full;
`endif

    // Tile packed as {00, 01, 10, 11}, row-major from the top.
    assign w_in     = {bus.i_in_00, bus.i_in_01, bus.i_in_10, bus.i_in_11};
    assign w_accept = bus.i_load && bus.o_load_ready;
    assign w_last   = (r_state == FEED) && (r_beat == 2'd2);

    always_comb begin
        w_state = r_state;
        w_beat  = r_beat;
        w_tile  = r_tile;
`ifdef ACT_SKEW_DOUBLE_BUFFER_EN
        w_shadow      = r_shadow;
        w_shadow_full = r_shadow_full;
`endif
        if (r_state == IDLE) begin
            if (w_accept) begin
                w_state = FEED;
                w_beat  = 2'd0;
                w_tile  = w_in;
            end
        end else if (!w_last) begin
            w_beat = r_beat + 2'd1;
`ifdef ACT_SKEW_DOUBLE_BUFFER_EN
            if (w_accept) begin
                w_shadow      = w_in;
                w_shadow_full = 1'b1;
            end
`endif
        end else begin
            w_beat = 2'd0;
`ifdef ACT_SKEW_DOUBLE_BUFFER_EN
            if (r_shadow_full) begin
                w_tile        = r_shadow;
                w_shadow_full = 1'b0;
            end else if (w_accept) begin
                w_tile = w_in;
            end else begin
                w_state = IDLE;
            end
`else
            w_state = IDLE;
`endif
        end
    end

    // Outputs are registered from the next-state decode so they line up with the beat.
    assign w_b0 = (w_state == FEED) && (w_beat == 2'd0);
    assign w_b1 = (w_state == FEED) && (w_beat == 2'd1);
    assign w_b2 = (w_state == FEED) && (w_beat == 2'd2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state           <= IDLE;
            r_beat            <= 2'd0;
            r_tile            <= '0;
`ifdef ACT_SKEW_DOUBLE_BUFFER_EN
            r_shadow          <= '0;
            r_shadow_full     <= 1'b0;
`endif
            bus.o_load_ready  <= 1'b1;
            bus.o_lane0_data  <= '0;
            bus.o_lane0_valid <= 1'b0;
            bus.o_lane1_data  <= '0;
            bus.o_lane1_valid <= 1'b0;
            bus.o_busy        <= 1'b0;
            bus.o_done        <= 1'b0;
            bus.o_tile_count  <= '0;
        end else begin
            r_state           <= w_state;
            r_beat            <= w_beat;
            r_tile            <= w_tile;
`ifdef ACT_SKEW_DOUBLE_BUFFER_EN
            r_shadow          <= w_shadow;
            r_shadow_full     <= w_shadow_full;
            bus.o_load_ready  <= !w_shadow_full;
`else
            bus.o_load_ready  <= (w_state == IDLE);
`endif
            bus.o_lane0_data  <= w_b0 ? w_tile[3*DATA_W +: DATA_W] : w_b1 ? w_tile[DATA_W +: DATA_W] : '0;
            bus.o_lane0_valid <= w_b0 || w_b1;
            bus.o_lane1_data  <= w_b1 ? w_tile[2*DATA_W +: DATA_W] : w_b2 ? w_tile[0 +: DATA_W] : '0;
            bus.o_lane1_valid <= w_b1 || w_b2;
            bus.o_busy        <= (w_state == FEED);
            bus.o_done        <= w_b2;
            bus.o_tile_count  <= bus.o_tile_count + {{(CNT_W-1){1'b0}}, w_b2};
        end
    end
endmodule

// File: tb/tb_activation_skew_feeder.sv
// tb_activation_skew_feeder: directed and random tiles checked against a tile-schedule model of activation_skew_feeder.
module tb_activation_skew_feeder;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 2;
`ifdef ACT_SKEW_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    // Model: every accepted tile with its accept edge and first-beat cycle.
    int q_acc[$];
    int q_start[$];
    logic [31:0] q_tile[$];

    activation_skew_feeder_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();
    activation_skew_feeder #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic expect_at(input int k, output logic [7:0] l0, output logic [7:0] l1,
                             output logic v0, output logic v1, output logic bz, output logic dn,
                             output logic rdy, output logic [CNT_W-1:0] cnt);
        int fed;
        fed = 0;
        l0 = '0; l1 = '0; v0 = 1'b0; v1 = 1'b0; bz = 1'b0; dn = 1'b0; rdy = 1'b1;
        foreach (q_start[i]) begin
            int b;
            logic [31:0] t;
            b = k - q_start[i];
            t = q_tile[i];
            if (b >= 2) fed++;
            if (b == 0) begin l0 = t[31:24]; v0 = 1'b1; end
            if (b == 1) begin l0 = t[15:8]; l1 = t[23:16]; v0 = 1'b1; v1 = 1'b1; end
            if (b == 2) begin l1 = t[7:0]; v1 = 1'b1; dn = 1'b1; end
            if (b >= 0 && b <= 2) bz = 1'b1;
            if ((q_acc[i] <= k && b < 0) || (!DB && b >= 0 && b <= 2)) rdy = 1'b0;
        end
        cnt = CNT_W'(fed);
    endtask

    task automatic check_cycle(output logic rdy);
        logic [7:0] l0, l1;
        logic v0, v1, bz, dn;
        logic [CNT_W-1:0] cnt;
        expect_at(cyc, l0, l1, v0, v1, bz, dn, rdy, cnt);
        chk("lane0_data", 32'(bus.o_lane0_data), 32'(l0));
        chk("lane0_valid", 32'(bus.o_lane0_valid), 32'(v0));
        chk("lane1_data", 32'(bus.o_lane1_data), 32'(l1));
        chk("lane1_valid", 32'(bus.o_lane1_valid), 32'(v1));
        chk("busy", 32'(bus.o_busy), 32'(bz));
        chk("done", 32'(bus.o_done), 32'(dn));
        chk("load_ready", 32'(bus.o_load_ready), 32'(rdy));
        chk("tile_count", 32'(bus.o_tile_count), 32'(cnt));
    endtask

    // Check the current cycle, drive this cycle's inputs, advance to the next cycle's midpoint.
    task automatic step(input logic ld, input logic [31:0] t);
        logic rdy;
        check_cycle(rdy);
        bus.i_load = ld;
        {bus.i_in_00, bus.i_in_01, bus.i_in_10, bus.i_in_11} = t;
        if (ld && rdy) begin
            int s;
            s = cyc + 1;
            if (q_start.size() > 0 && q_start[$] + 3 > s) s = q_start[$] + 3;
            q_acc.push_back(cyc + 1);
            q_start.push_back(s);
            q_tile.push_back(t);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        logic rdy;
        bus.i_load = 1'b0;
        {bus.i_in_00, bus.i_in_01, bus.i_in_10, bus.i_in_11} = '0;
        @(negedge clk);
        check_cycle(rdy);
        @(negedge clk);
        reset = 1'b0;
        // Single tile, with inputs forced to 0xFF right after acceptance.
        step(1'b1, 32'h01020304);
        step(1'b0, 32'hFFFFFFFF);
        repeat (4) step(1'b0, 32'hFFFFFFFF);
        // Load attempted during beat1 of a tile.
        step(1'b1, 32'h11223344);
        step(1'b0, 32'h0);
        step(1'b1, 32'h05060708);
        repeat (6) step(1'b0, 32'h0);
        // Back-to-back tiles, then a load against a full shadow.
        step(1'b1, 32'h01020304);
        step(1'b1, 32'h090A0B0C);
        step(1'b0, 32'h0);
        step(1'b0, 32'h0);
        step(1'b1, 32'h0D0E0F10);
        step(1'b1, 32'h21222324);
        repeat (8) step(1'b0, 32'h0);
        // Reset mid-beat1 discards the tile immediately.
        step(1'b1, 32'hA1A2A3A4);
        step(1'b0, 32'h0);
        check_cycle(rdy);
        #2 reset = 1'b1;
        #1;
        q_acc.delete();
        q_start.delete();
        q_tile.delete();
        check_cycle(rdy);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        reset = 1'b0;
        // Random loads; tile_count wraps every 4 tiles.
        repeat (300) step($urandom_range(0, 3) != 0, $urandom());
        repeat (8) step(1'b0, 32'h0);
        chk("tiles_fed_total", 32'(bus.o_tile_count), 32'(q_start.size() % (1 << CNT_W)));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
